// File: rtl/fht_pkg.sv
// -----------------------------------------------------------------------------
// fht_pkg
// Shared definitions for the FHT input loader:
//   - state_t        : loader FSM states (fill / drain / wait / start)
//   - A_BIT/K_BIT/B_BIT for the default configuration, plus helper functions
//     that compute the same widths for any (POINT, N_BANK) pair
//   - sign_extend()  : widens a w-bit two's-complement value to 64 bits
// -----------------------------------------------------------------------------
package fht_pkg;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_WAIT  = 2'd2,
        ST_START = 2'd3
    } state_t;

    // Default configuration of the loader.
    localparam int DEF_N_BANK = 4;
    localparam int DEF_POINT  = 1024;
    localparam int DEF_D_BIT  = 16;

    // Bank address width, sample counter width and bank select width for the
    // default configuration.
    localparam int A_BIT = $clog2(DEF_POINT / DEF_N_BANK);
    localparam int K_BIT = $clog2(DEF_POINT);
    localparam int B_BIT = $clog2(DEF_N_BANK);

    // Width helpers so a loader built with other parameters derives its
    // widths with exactly the same formulas.
    function automatic int addr_bits(input int point, input int n_bank);
        return $clog2(point / n_bank);
    endfunction

    function automatic int count_bits(input int point);
        return $clog2(point);
    endfunction

    function automatic int bank_bits(input int n_bank);
        return $clog2(n_bank);
    endfunction

    // Replicates bit w-1 of x into every bit above it. Callers zero-extend
    // their operand to 64 bits and cast the result back to the width needed.
    function automatic logic [63:0] sign_extend(input logic [63:0] x, input int w);
        logic [63:0] r;
        r = x;
        for (int i = 0; i < 64; i++) begin
            if (i >= w) begin
                r[i] = x[w-1];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fht_bitrev.sv
// -----------------------------------------------------------------------------
// fht_bitrev
// Purely combinational bit reversal: o_data[i] = i_data[W-1-i].
// Ports:
//   i_data  in  W  value to reverse
//   o_data  out W  reversed value
// -----------------------------------------------------------------------------
module fht_bitrev #(
    parameter int W = 4
) (
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data
);

    for (genvar gi = 0; gi < W; gi++) begin : g_rev
        assign o_data[gi] = i_data[W-1-gi];
    end

endmodule

// File: rtl/fht_input_loader.sv
// -----------------------------------------------------------------------------
// fht_input_loader
// Streaming front-end for the FHT core. ADC samples arrive on a valid/ready
// handshake, are sign-extended by one bit and scattered over N_BANK RAM banks
// at natural or bit-reversed positions. Two bank sets are filled ping-pong:
// a completed frame is handed to the core while the other set is filled.
//
// Ports:
//   iCLK        in   1       clock
//   iRESET      in   1       synchronous active-high reset
//   iDATA       in   D_BIT-1 signed ADC sample
//   iVALID      in   1       sample present
//   oREADY      out  1       loader accepts a sample this cycle
//   iBITREV     in   1       placement mode, latched at frame start
//   iABORT      in   1       discard the partial frame (FILL only)
//   iFHT_DONE   in   1       core finished the current transform (pulse)
//   oDATA       out  D_BIT   sign-extended sample for the banks
//   oADDR_WR    out  A_W     bank address
//   oWE         out  N_BANK  one-hot bank write enable
//   oBUF_SEL    out  1       bank set being filled (0 = A, 1 = B)
//   oSTART      out  1       one-cycle start pulse to the core
//   oSTART_SEL  out  1       bank set handed to the core
//   oFHT_BUSY   out  1       core owns a bank set
//   oOVF        out  1       sticky: sample offered while not ready
// -----------------------------------------------------------------------------
module fht_input_loader
    import fht_pkg::*;
#(
    parameter  int N_BANK = DEF_N_BANK,
    parameter  int POINT  = DEF_POINT,
    parameter  int D_BIT  = DEF_D_BIT,
    localparam int A_W    = addr_bits(POINT, N_BANK),
    localparam int K_W    = count_bits(POINT),
    localparam int B_W    = bank_bits(N_BANK)
) (
    input  logic              iCLK,
    input  logic              iRESET,
    input  logic [D_BIT-2:0]  iDATA,
    input  logic              iVALID,
    output logic              oREADY,
    input  logic              iBITREV,
    input  logic              iABORT,
    input  logic              iFHT_DONE,
    output logic [D_BIT-1:0]  oDATA,
    output logic [A_W-1:0]    oADDR_WR,
    output logic [N_BANK-1:0] oWE,
    output logic              oBUF_SEL,
    output logic              oSTART,
    output logic              oSTART_SEL,
    output logic              oFHT_BUSY,
    output logic              oOVF
);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t              r_state;
    state_t              w_state_next;

    logic [K_W-1:0]      r_k;          // index of the next sample in the frame
    logic                r_mode;       // placement mode latched at frame start
    logic                r_buf_sel;
    logic                r_start;
    logic                r_start_sel;
    logic                r_busy;
    logic                r_ovf;
    logic [N_BANK-1:0]   r_we;
    logic [A_W-1:0]      r_addr;
    logic [D_BIT-1:0]    r_data;

    // -------------------------------------------------------------------------
    // Placement
    // -------------------------------------------------------------------------
    logic [K_W-1:0]      w_k_rev;
    logic [K_W-1:0]      w_pos;
    logic [B_W-1:0]      w_bank;
    logic [A_W-1:0]      w_addr;
    logic [N_BANK-1:0]   w_we_onehot;
    logic [D_BIT-1:0]    w_data_ext;

    fht_bitrev #(
        .W (K_W)
    ) u_bitrev (
        .i_data (r_k),
        .o_data (w_k_rev)
    );

    assign w_pos  = r_mode ? w_k_rev : r_k;
    // Low bits pick the bank, the rest form the address inside that bank.
    assign w_bank = w_pos[B_W-1:0];
    assign w_addr = w_pos[K_W-1:B_W];

    for (genvar gi = 0; gi < N_BANK; gi++) begin : g_we
        assign w_we_onehot[gi] = (w_bank == B_W'(gi));
    end

    assign w_data_ext = D_BIT'(sign_extend(64'(iDATA), D_BIT - 1));

    // -------------------------------------------------------------------------
    // Handshake
    // -------------------------------------------------------------------------
    logic w_ready;
    logic w_accept;
    logic w_abort;
    logic w_write;
    logic w_last;

    assign w_ready  = (r_state == ST_FILL);
    assign w_accept = iVALID & w_ready;
    assign w_abort  = iABORT & w_ready;
    // An abort in the same cycle as a handshake drops that sample as well:
    // the frame restarts cleanly at k = 0.
    assign w_write  = w_accept & ~w_abort;
    assign w_last   = (r_k == K_W'(POINT - 1));

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_FILL: begin
                if (w_write && w_last) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // The core still owns the other set: hold the frame until
                // it reports completion.
                w_state_next = r_busy ? ST_WAIT : ST_START;
            end
            ST_WAIT: begin
                if (iFHT_DONE) begin
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                w_state_next = ST_FILL;
            end
            default: begin
                w_state_next = ST_FILL;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            r_state     <= ST_FILL;
            r_k         <= '0;
            r_mode      <= iBITREV;
            r_buf_sel   <= 1'b0;
            r_start     <= 1'b0;
            r_start_sel <= 1'b0;
            r_busy      <= 1'b0;
            r_ovf       <= 1'b0;
            r_we        <= '0;
            r_addr      <= '0;
            r_data      <= '0;
        end else begin
            r_state <= w_state_next;

            // oSTART and oSTART_SEL are loaded on entry so they are valid
            // during the START cycle itself.
            r_start <= (w_state_next == ST_START);
            if (w_state_next == ST_START) begin
                r_start_sel <= r_buf_sel;
            end

            // Bank write port: enable pulses for one cycle, address and data
            // hold their last value between writes.
            r_we <= w_write ? w_we_onehot : '0;
            if (w_write) begin
                r_addr <= w_addr;
                r_data <= w_data_ext;
                r_k    <= r_k + K_W'(1);
            end

            if (w_abort) begin
                r_k    <= '0;
                r_mode <= iBITREV;
            end

            // Setting busy in START takes priority over a coincident done.
            if (r_state == ST_START) begin
                r_busy    <= 1'b1;
                r_buf_sel <= ~r_buf_sel;
                r_k       <= '0;
                r_mode    <= iBITREV;
            end else if (iFHT_DONE) begin
                r_busy <= 1'b0;
            end

            if (iVALID && !w_ready) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign oREADY     = w_ready;
    assign oDATA      = r_data;
    assign oADDR_WR   = r_addr;
    assign oWE        = r_we;
    assign oBUF_SEL   = r_buf_sel;
    assign oSTART     = r_start;
    assign oSTART_SEL = r_start_sel;
    assign oFHT_BUSY  = r_busy;
    assign oOVF       = r_ovf;

endmodule

// File: doc/fht_input_loader.md
# fht_input_loader

Parametrised streaming front-end for the FHT core. It accepts ADC samples over a valid/ready handshake and sign-extends each one by a single bit. Each sample is scattered into N_BANK RAM banks at natural or bit-reversed positions. Two bank sets (A/B) are used ping-pong: when a frame is complete the loader starts the FHT on that set and continues filling the other.

## Interface
- N_BANK, 4: number of RAM banks. Power of two, at least 2.
- POINT, 1024: samples per frame. Power of two, at least 2·N_BANK.
- D_BIT, 16: bank word width. ADC samples are D_BIT-1 bits.
- iCLK  in  1  clock.
- iRESET  in  1  reset, synchronous, active-high.
- iDATA  in  D_BIT-1  signed ADC sample.
- iVALID  in  1  sample present.
- oREADY  out  1  loader accepts a sample this cycle.
- iBITREV  in  1  1 = bit-reversed placement, 0 = natural. Sampled only at frame start.
- iABORT  in  1  discard the partial frame.
- iFHT_DONE  in  1  one-cycle pulse from the core: the current transform has finished.
- oDATA  out  D_BIT  sign-extended sample to the banks.
- oADDR_WR  out  log2(POINT/N_BANK)  bank address.
- oWE  out  N_BANK  one-hot bank write enable.
- oBUF_SEL  out  1  bank set being filled (0 = A, 1 = B).
- oSTART  out  1  one-cycle start pulse to the core.
- oSTART_SEL  out  1  bank set handed to the core; held until the next oSTART.
- oFHT_BUSY  out  1  core owns a bank set.
- oOVF  out  1  sticky: a sample arrived while oREADY was 0.

## Operation
- **Accept:** a sample is accepted when iVALID and oREADY are both 1. The sample counter k runs 0..POINT-1.
- **Placement:**
  - p = bitrev(k) over log2(POINT) bits if the latched mode is 1, otherwise p = k.
  - Bank = p mod N_BANK; oADDR_WR = p / N_BANK.
  - oDATA = {iDATA msb, iDATA}.
- **States:** FILL, DRAIN, WAIT, START.
  - FILL: oREADY = 1. Accepting sample k = POINT-1 moves to DRAIN.
  - DRAIN: 1 cycle, the last write is on the bus. Go to WAIT if oFHT_BUSY, else START.
  - WAIT: stay until iFHT_DONE, then go to START.
  - START: 1 cycle. oSTART = 1, oSTART_SEL = oBUF_SEL, set busy, toggle oBUF_SEL, k = 0, relatch iBITREV. Return to FILL.
- **Busy flag:** set in START, cleared by iFHT_DONE. If both occur in the same cycle, set wins. iFHT_DONE while not busy is ignored.
- **Abort:** iABORT in FILL clears k to 0 and relatches iBITREV. oBUF_SEL is unchanged. A write already registered still completes. iABORT in any other state is ignored.
- **Overflow:** iVALID with oREADY = 0 sets oOVF. It clears only on iRESET.
- **Reset values:**
  - State FILL, k = 0, mode latched from iBITREV.
  - oBUF_SEL = 0, oSTART_SEL = 0, oSTART = 0, busy = 0, oOVF = 0.
  - oWE = 0, oADDR_WR = 0, oDATA = 0.
  - oREADY is 1 from the first cycle after reset. Reset mid-frame discards everything.

## Timing
- Accept in cycle t: oWE (one bit), oADDR_WR and oDATA are registered and valid in cycle t+1, for one cycle.
- The last accept in cycle t gives DRAIN at t+1. oSTART is at t+2 at the earliest.
- oREADY = 0 from t+1 through the START cycle. oREADY = 1 again at t+3 (no wait) or at the cycle after START (wait).
- iFHT_DONE in cycle u while in WAIT: oSTART at u+1.
- Back-to-back accepts are allowed every cycle. oWE never has more than one bit set.

## Structure
- Shared package fht_pkg holds:
  - the state enum;
  - the localparams A_BIT = $clog2(POINT/N_BANK), K_BIT = $clog2(POINT) and B_BIT = $clog2(N_BANK);
  - a sign-extend function.
- Sub-module fht_bitrev: combinational bit reversal, parameter W.
- Everything else lives in a single always_ff block plus next-state logic.

## Test plan
All scenarios use POINT = 16, N_BANK = 4, D_BIT = 16.
- **Natural order, sign extension:** iBITREV = 0, stream samples 0..15 continuously.
  - Sample k lands in bank k%4 at address k/4.
  - Input -5 (15'h7FFB) gives oDATA = 16'hFFFB.
  - oSTART occurs exactly 2 cycles after the 16th accept, with oSTART_SEL = 0.
- **Bit-reversed order:** iBITREV = 1.
  - k = 1 goes to bank 0, address 2.
  - k = 3 goes to bank 0, address 3.
  - k = 6 goes to bank 2, address 1.
  - Every bank address is written exactly once per frame.
- **Ping-pong stall:** fill frame 2 without any iFHT_DONE.
  - Loader holds in WAIT with oREADY = 0.
  - Pulse iFHT_DONE: oSTART occurs next cycle with oSTART_SEL = 1, then oBUF_SEL = 0.
- **Overflow:** drive iVALID during the stall.
  - oOVF goes to 1 and stays 1 across later frames until iRESET.
- **Abort:** accept 7 samples, assert iABORT, then send 16 samples.
  - The first write after the abort goes to bank 0, address 0.
  - oSTART occurs after the 16 new samples only.
- **Reset mid-frame and collision:** assert iRESET mid-frame.
  - All outputs return to reset values and the next sample goes to bank 0, address 0.
  - iFHT_DONE coinciding with the START cycle leaves oFHT_BUSY = 1.
